// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit order, blank pattern and the active-low
// hex glyph table used by the scan driver.
package seg_pkg;

  localparam int SEG_W = 7;

  // seg[6:0] = {a,b,c,d,e,f,g}
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] LIT_A = 7'b1 << SEG_A;
  localparam logic [SEG_W-1:0] LIT_B = 7'b1 << SEG_B;
  localparam logic [SEG_W-1:0] LIT_C = 7'b1 << SEG_C;
  localparam logic [SEG_W-1:0] LIT_D = 7'b1 << SEG_D;
  localparam logic [SEG_W-1:0] LIT_E = 7'b1 << SEG_E;
  localparam logic [SEG_W-1:0] LIT_F = 7'b1 << SEG_F;
  localparam logic [SEG_W-1:0] LIT_G = 7'b1 << SEG_G;

  // Glyphs are written as the set of lit segments, then inverted for the pins.
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPH = {
    ~(LIT_A | LIT_E | LIT_F | LIT_G),                         // F
    ~(LIT_A | LIT_D | LIT_E | LIT_F | LIT_G),                 // E
    ~(LIT_B | LIT_C | LIT_D | LIT_E | LIT_G),                 // d
    ~(LIT_A | LIT_D | LIT_E | LIT_F),                         // C
    ~(LIT_C | LIT_D | LIT_E | LIT_F | LIT_G),                 // b
    ~(LIT_A | LIT_B | LIT_C | LIT_E | LIT_F | LIT_G),         // A
    ~(LIT_A | LIT_B | LIT_C | LIT_D | LIT_F | LIT_G),         // 9
    ~(LIT_A | LIT_B | LIT_C | LIT_D | LIT_E | LIT_F | LIT_G), // 8
    ~(LIT_A | LIT_B | LIT_C),                                 // 7
    ~(LIT_A | LIT_C | LIT_D | LIT_E | LIT_F | LIT_G),         // 6
    ~(LIT_A | LIT_C | LIT_D | LIT_F | LIT_G),                 // 5
    ~(LIT_B | LIT_C | LIT_F | LIT_G),                         // 4
    ~(LIT_A | LIT_B | LIT_C | LIT_D | LIT_G),                 // 3
    ~(LIT_A | LIT_B | LIT_D | LIT_E | LIT_G),                 // 2
    ~(LIT_B | LIT_C),                                         // 1
    ~(LIT_A | LIT_B | LIT_C | LIT_D | LIT_E | LIT_F)          // 0
  };

endpackage

// File: rtl/hex_to_segments.sv
// Combinational hex nibble to active-low {a..g} segment pattern.
module hex_to_segments
  import seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_n_o
);

  assign seg_n_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode driver: double-buffered hex word,
// per-digit dp/blank, leading-zero suppression and a dark guard at each slot start.
module seven_segment_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [PS_W-1:0]       PS_GUARD = PS_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [PS_W-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    presc_tc;
  logic                    frame_wrap;
  logic [3:0]              cur_nib;
  logic [SEG_W-1:0]        glyph;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    zero_run;
  logic                    digit_dark;
  logic                    in_guard;
  logic [NUM_DIGITS-1:0]   an_sel;

  always_comb begin
    presc_tc   = (presc_q == PS_LAST);
    frame_wrap = enable && presc_tc && (idx_q == IDX_LAST);
    presc_d    = '0;
    idx_d      = '0;
    if (enable) begin
      presc_d = presc_tc ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_tc) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // A load coinciding with the frame boundary flows through the shadow
  // next-state straight into the display buffer.
  always_comb begin
    sh_val_d     = load ? value    : sh_val_q;
    sh_dp_d      = load ? dp_in    : sh_dp_q;
    sh_blank_d   = load ? blank_in : sh_blank_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_wrap) begin
      disp_val_d   = sh_val_d;
      disp_dp_d    = sh_dp_d;
      disp_blank_d = sh_blank_d;
    end
  end

  assign cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];

  hex_to_segments u_hex (
    .nibble_i (cur_nib),
    .seg_n_o  (glyph)
  );

  // Walk down from the top digit; a digit is a leading zero while every
  // digit from it upward is zero. Digit 0 always shows.
  always_comb begin
    zero_run = lz_suppress;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_run;
    end
    lz_dark[0] = 1'b0;
  end

  always_comb begin
    digit_dark    = disp_blank_q[idx_q] | lz_dark[idx_q];
    in_guard      = (presc_q < PS_GUARD);
    an_sel        = '0;
    an_sel[idx_q] = 1'b1;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    an_d          = AN_OFF;
    fs_d          = enable && (idx_q == '0) && (presc_q == PS_GUARD);
    if (enable && !in_guard) begin
      an_d  = an_sel ^ AN_OFF;
      seg_d = digit_dark ? SEG_BLANK : glyph;
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= AN_OFF;
      fs_q         <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
